pixel_ram_arbiter: RTL and testbench

- Sequences and shares the single-port-write / single-port-read 784x1 pixel RAM (28x28 binary drawing canvas).
- Three clients:
  - a draw client (pixel painting from the input front end);
  - a clear command (sweeps the canvas to a constant);
  - a scan reader that streams all pixels in address order to the classifier with valid/ready handshaking.
- Sits between the canvas RAM and those clients.
- Drives the RAM's clock-domain ports directly; the RAM has 1-cycle registered read latency.

---
 rtl/pixel_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_pixel_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_ram_arbiter.sv
// rtl/pixel_ram_arbiter.sv - shares the 784x1 canvas RAM between draw, clear sweep and scan streaming
// Optional PIXEL_COUNT_EN adds ones_count: number of set pixels seen by the last completed scan.
module pixel_ram_arbiter #(
    parameter int   N_PIXELS  = 784,
    parameter int   ADDR_W    = 10,
    parameter logic CLEAR_VAL = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic              draw_data,
    output logic              draw_ack,
    input  logic              clear_start,
    input  logic              scan_start,
    output logic              busy,
    output logic              done,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic              scan_pixel,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_last,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_data,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic              ram_q
`ifdef PIXEL_COUNT_EN
    ,
    output logic [ADDR_W-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN_ADDR,
        S_SCAN_OUT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_PIXELS - 1);
    localparam logic [ADDR_W:0]   N_PIX_EXT = (ADDR_W + 1)'(N_PIXELS);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              done_q;

    logic in_idle;
    logic draw_grant;
    logic draw_in_range;
    logic at_last;
    logic beat_accept;

    assign in_idle       = (state_q == S_IDLE);
    // A draw only wins an otherwise quiet IDLE cycle; colliding draws are left pending.
    assign draw_grant    = in_idle && !reset && draw_req && !clear_start && !scan_start;
    assign draw_in_range = ({1'b0, draw_addr} < N_PIX_EXT);
    assign at_last       = (idx_q == LAST_IDX);
    assign beat_accept   = (state_q == S_SCAN_OUT) && scan_ready;

    assign draw_ack   = draw_grant;
    assign busy       = !in_idle;
    assign done       = done_q;
    assign scan_valid = (state_q == S_SCAN_OUT);
    assign scan_last  = scan_valid && at_last;
    assign scan_pixel = scan_valid && ram_q;
    assign scan_addr  = scan_valid ? idx_q : '0;

    always_comb begin
        ram_wren      = 1'b0;
        ram_wraddress = '0;
        ram_data      = 1'b0;
        ram_rdaddress = '0;
        case (state_q)
            S_IDLE: begin
                if (draw_grant && draw_in_range) begin
                    ram_wren      = 1'b1;
                    ram_wraddress = draw_addr;
                    ram_data      = draw_data;
                end
            end
            S_CLEAR: begin
                ram_wren      = 1'b1;
                ram_wraddress = idx_q;
                ram_data      = CLEAR_VAL;
            end
            S_SCAN_ADDR, S_SCAN_OUT: ram_rdaddress = idx_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_start) begin
                        state_q <= S_CLEAR;
                        idx_q   <= '0;
                    end else if (scan_start) begin
                        state_q <= S_SCAN_ADDR;
                        idx_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (at_last) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                // RAM read is registered, so each pixel needs one address cycle first.
                S_SCAN_ADDR: state_q <= S_SCAN_OUT;
                S_SCAN_OUT: begin
                    if (beat_accept) begin
                        if (at_last) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= S_SCAN_ADDR;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PIXEL_COUNT_EN
    logic [ADDR_W-1:0] run_cnt_q;
    logic [ADDR_W-1:0] ones_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_cnt_q    <= '0;
            ones_count_q <= '0;
        end else if (in_idle && scan_start && !clear_start) begin
            run_cnt_q <= '0;
        end else if (beat_accept) begin
            run_cnt_q <= run_cnt_q + ADDR_W'(scan_pixel);
            // Published together with done so the count always describes a whole scan.
            if (scan_last) begin
                ones_count_q <= run_cnt_q + ADDR_W'(scan_pixel);
            end
        end
    end

    assign ones_count = ones_count_q;
`endif

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// tb/tb_pixel_ram_arbiter.sv - self-checking bench for pixel_ram_arbiter with a behavioural canvas RAM
module tb_pixel_ram_arbiter;

    localparam int N  = 784;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          draw_req;
    logic [AW-1:0] draw_addr;
    logic          draw_data;
    logic          draw_ack;
    logic          clear_start;
    logic          scan_start;
    logic          busy;
    logic          done;
    logic          scan_valid;
    logic          scan_ready;
    logic          scan_pixel;
    logic [AW-1:0] scan_addr;
    logic          scan_last;
    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic          ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic          ram_q;
`ifdef PIXEL_COUNT_EN
    logic [AW-1:0] ones_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic mem [0:1023];
    bit   ref_canvas [0:N-1];

    always #5 clock = ~clock;

    pixel_ram_arbiter #(.N_PIXELS(N), .ADDR_W(AW), .CLEAR_VAL(1'b0)) dut (
        .clock(clock), .reset(reset),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data), .draw_ack(draw_ack),
        .clear_start(clear_start), .scan_start(scan_start), .busy(busy), .done(done),
        .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_pixel(scan_pixel),
        .scan_addr(scan_addr), .scan_last(scan_last),
        .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
`ifdef PIXEL_COUNT_EN
        , .ones_count(ones_count)
`endif
    );

    // Canvas RAM: write port plus registered read (old data on read-during-write).
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          data;
        logic          clr;
        logic          scn;
        logic          e_ack;
        logic          e_wren;
        logic [AW-1:0] e_wa;
        logic          e_data;
        logic          e_busy_next;
        logic          e_wren_next;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        draw_req = 0; draw_addr = '0; draw_data = 0;
        clear_start = 0; scan_start = 0; scan_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic do_clear();
        int n;
        clear_start = 1;
        tick();
        clear_start = 0;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk("clear_finishes", int'(n < 2000), 1);
        for (int i = 0; i < N; i++) ref_canvas[i] = 0;
        tick();
    endtask

    task automatic draw_pixel(input int a, input bit d);
        draw_req = 1; draw_addr = AW'(a); draw_data = d;
        #1;
        chk("draw_ack", int'(draw_ack), 1);
        chk("draw_wren", int'(ram_wren), int'(a < N));
        if (a < N) ref_canvas[a] = d;
        tick();
        draw_req = 0;
    endtask

    function automatic int model_ones();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(ref_canvas[i]);
        return c;
    endfunction

    // mode 0: always ready, 1: random ready, 2: 10-cycle stall on beat 27 with draws pending
    task automatic run_scan(input int mode, output int beats, output int beat_err,
                            output int ones, output int last_cyc, output int done_ok,
                            output int stall_err, output int ack_err);
        int  cyc, stall;
        bit  finished, rdy, snap_pix;
        logic [AW-1:0] snap_addr;
        beats = 0; beat_err = 0; ones = 0; last_cyc = -1; done_ok = 0;
        stall_err = 0; ack_err = 0; cyc = 0; stall = 0; finished = 0;
        snap_pix = 0; snap_addr = '0;
        scan_start = 1;
        draw_req = (mode == 2); draw_addr = AW'(27); draw_data = 0;
        while (!finished && cyc < 20000) begin
            #1;
            if (draw_ack !== 1'b0 || ram_wren !== 1'b0) ack_err++;
            rdy = 1;
            if (scan_valid) begin
                if (beats >= N) beat_err++;
                else if (int'(scan_addr) != beats || scan_pixel !== ref_canvas[beats] ||
                         scan_last !== (beats == N - 1)) beat_err++;
                if (mode == 1) rdy = bit'($urandom % 2);
                if (mode == 2 && beats == 27 && stall < 10) begin
                    if (stall == 0) begin
                        snap_pix = scan_pixel; snap_addr = scan_addr;
                    end else if (scan_pixel !== snap_pix || scan_addr !== snap_addr) begin
                        stall_err++;
                    end
                    rdy = 0;
                    stall++;
                end
                if (rdy) begin
                    ones += int'(scan_pixel);
                    beats++;
                    if (scan_last) begin
                        last_cyc = cyc;
                        finished = 1;
                    end
                end
            end
            scan_ready = rdy;
            tick();
            cyc++;
            scan_start = 0;
        end
        if (mode == 2 && stall != 10) stall_err++;
        draw_req = 0; scan_ready = 0;
        #1;
        done_ok = int'(done === 1'b1);
        tick();
        if (done !== 1'b0 || busy !== 1'b0) done_ok = 0;
    endtask

    initial begin
        int n, addr_err, sv, dn, beats, berr, ones, lcyc, dok, serr, aerr, rerr, a;
        bit exp_w;
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
        for (int i = 0; i < N; i++) ref_canvas[i] = 0;

        //          req  addr     dat  clr  scn  ack  wren wa       data bsyN wrN
        vecs[0] = '{1'b1, 10'd5,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd5,   1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 10'd800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 10'd783, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd783, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 10'd784, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 10'd5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 10'd5,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 10'd9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0};

        do_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_scan_valid", int'(scan_valid), 0);
        chk("rst_scan_last", int'(scan_last), 0);
        chk("rst_draw_ack", int'(draw_ack), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_addrs", int'(ram_wraddress) + int'(ram_rdaddress) + int'(scan_addr), 0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            draw_req = vecs[v].req; draw_addr = vecs[v].addr; draw_data = vecs[v].data;
            clear_start = vecs[v].clr; scan_start = vecs[v].scn;
            #1;
            chk($sformatf("vec%0d_ack", v), int'(draw_ack), int'(vecs[v].e_ack));
            chk($sformatf("vec%0d_wren", v), int'(ram_wren), int'(vecs[v].e_wren));
            if (vecs[v].e_wren) begin
                chk($sformatf("vec%0d_wraddr", v), int'(ram_wraddress), int'(vecs[v].e_wa));
                chk($sformatf("vec%0d_wdata", v), int'(ram_data), int'(vecs[v].e_data));
            end
            tick();
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_busy_next", v), int'(busy), int'(vecs[v].e_busy_next));
            chk($sformatf("vec%0d_wren_next", v), int'(ram_wren), int'(vecs[v].e_wren_next));
        end

        // Reset in the middle of a clear sweep.
        do_reset();
        clear_start = 1;
        tick();
        clear_start = 0;
        n = 0;
        while (!(ram_wren === 1'b1 && int'(ram_wraddress) == 300) && n < 1000) begin
            tick();
            n++;
        end
        chk("midclear_reach_300", int'(n < 1000), 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("midclear_busy", int'(busy), 0);
        chk("midclear_wren", int'(ram_wren), 0);
        tick();

        // All three requests at once: clear wins, draw not acked, no scan.
        clear_start = 1; scan_start = 1; draw_req = 1; draw_addr = AW'(10); draw_data = 1;
        #1;
        chk("collide_ack", int'(draw_ack), 0);
        chk("collide_wren", int'(ram_wren), 0);
        tick();
        idle_inputs();
        n = 0; addr_err = 0; sv = 0; dn = 0;
        while (busy && n < 2000) begin
            if (ram_wren !== 1'b1 || ram_wraddress !== AW'(n) || ram_data !== 1'b0) addr_err++;
            sv += int'(scan_valid);
            dn += int'(done);
            n++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            dn += int'(done);
            sv += int'(scan_valid);
            tick();
        end
        chk("clear_busy_cycles", n, N);
        chk("clear_addr_seq_errs", addr_err, 0);
        chk("clear_scan_seen", sv, 0);
        chk("clear_done_pulses", dn, 1);
        for (int i = 0; i < N; i++) ref_canvas[i] = 0;

        draw_pixel(0, 1);
        draw_pixel(27, 1);
        draw_pixel(783, 1);
        draw_pixel(800, 1);

        run_scan(0, beats, berr, ones, lcyc, dok, serr, aerr);
        chk("scan0_beats", beats, N);
        chk("scan0_beat_errs", berr, 0);
        chk("scan0_ones", ones, 3);
        chk("scan0_last_cycle", lcyc, 1568);
        chk("scan0_done", dok, 1);
`ifdef PIXEL_COUNT_EN
        chk("ones_count_after_scan", int'(ones_count), 3);
`endif

        run_scan(2, beats, berr, ones, lcyc, dok, serr, aerr);
        chk("stall_beats", beats, N);
        chk("stall_beat_errs", berr, 0);
        chk("stall_stable_errs", serr, 0);
        chk("stall_draw_not_acked", aerr, 0);
        chk("stall_last_cycle", lcyc, 1578);
        chk("stall_done", dok, 1);

        do_clear();
`ifdef PIXEL_COUNT_EN
        chk("ones_count_after_clear", int'(ones_count), 3);
`endif

        for (int r = 0; r < 2; r++) begin
            rerr = 0;
            for (int i = 0; i < 300; i++) begin
                draw_req = ($urandom % 3) != 0;
                a = ($urandom % 5 == 0) ? int'($urandom_range(784, 1023)) : int'($urandom_range(0, 783));
                draw_addr = AW'(a);
                draw_data = bit'($urandom % 2);
                #1;
                exp_w = draw_req && (a < N);
                if (draw_ack !== draw_req || ram_wren !== exp_w ||
                    (exp_w && (int'(ram_wraddress) != a || ram_data !== draw_data))) rerr++;
                if (exp_w) ref_canvas[a] = draw_data;
                tick();
            end
            idle_inputs();
            chk($sformatf("rand%0d_draw_errs", r), rerr, 0);
            run_scan(1, beats, berr, ones, lcyc, dok, serr, aerr);
            chk($sformatf("rand%0d_beats", r), beats, N);
            chk($sformatf("rand%0d_beat_errs", r), berr, 0);
            chk($sformatf("rand%0d_ones", r), ones, model_ones());
            chk($sformatf("rand%0d_done", r), dok, 1);
`ifdef PIXEL_COUNT_EN
            chk($sformatf("rand%0d_ones_count", r), int'(ones_count), model_ones());
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
